// File: rtl/if_id_pipe_pkg.sv
// Shared widths and state encodings for the fetch/decode pipeline boundary.
package if_id_pipe_pkg;

  localparam int WORD      = 64;
  localparam int INSTR_LEN = 32;

  typedef enum logic [1:0] {
    IFID_EMPTY = 2'd0,
    IFID_ONE   = 2'd1,
    IFID_TWO   = 2'd2
  } ifid_state_e;

endpackage

// File: rtl/ifid_entry.sv
// One pipeline entry: a valid bit plus PC and instruction payload.
// Load sets valid and captures payload; clear drops valid and keeps the payload.
module ifid_entry #(
  parameter int PC_W = 64,
  parameter int IW   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [PC_W-1:0] i_pc,
  input  logic [IW-1:0]   i_instr,
  output logic            o_valid,
  output logic [PC_W-1:0] o_pc,
  output logic [IW-1:0]   o_instr
);

  logic            r_valid;
  logic [PC_W-1:0] r_pc;
  logic [IW-1:0]   r_instr;

  // NOTE: payload is reset too, so decode sees zeros after reset rather than X.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/if_id_pipe.sv
// Fetch-to-decode pipeline register with valid/ready handshake and branch flush.
// Define IFID_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module if_id_pipe
  import if_id_pipe_pkg::*;
#(
  parameter int PC_W = WORD,
  parameter int IW   = INSTR_LEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [IW-1:0]   in_instruction,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [IW-1:0]   out_instruction
);

  logic            w_in_xfer;
  logic            w_out_xfer;
  logic            w_main_load;
  logic            w_main_clear;
  logic            w_main_valid;
  logic [PC_W-1:0] w_main_pc_d;
  logic [IW-1:0]   w_main_instr_d;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = w_main_valid && out_ready;

  ifid_entry #(.PC_W(PC_W), .IW(IW)) u_main (
    .clk     (clk),
    .rst_n   (reset),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_pc    (w_main_pc_d),
    .i_instr (w_main_instr_d),
    .o_valid (w_main_valid),
    .o_pc    (out_pc),
    .o_instr (out_instruction)
  );

  assign out_valid = w_main_valid;

`ifdef IFID_SKID_EN
  logic            w_skid_load;
  logic            w_skid_clear;
  logic            w_skid_valid;
  logic [PC_W-1:0] w_skid_pc;
  logic [IW-1:0]   w_skid_instr;
  logic            w_main_from_skid;
  ifid_state_e     w_state;
  ifid_state_e     w_state_nxt;
  logic            r_in_ready;

  ifid_entry #(.PC_W(PC_W), .IW(IW)) u_skid (
    .clk     (clk),
    .rst_n   (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_pc    (in_pc),
    .i_instr (in_instruction),
    .o_valid (w_skid_valid),
    .o_pc    (w_skid_pc),
    .o_instr (w_skid_instr)
  );

  // The valid bits of the two entries are the state; no separate encoding is kept.
  assign w_state = w_skid_valid ? IFID_TWO : (w_main_valid ? IFID_ONE : IFID_EMPTY);

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    w_main_load      = 1'b0;
    w_main_clear     = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    w_main_from_skid = 1'b0;
    w_state_nxt      = w_state;
    if (flush) begin
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
      w_state_nxt  = IFID_EMPTY;
    end else begin
      case (w_state)
        IFID_EMPTY: begin
          if (w_in_xfer) begin
            w_main_load = 1'b1;
            w_state_nxt = IFID_ONE;
          end
        end
        IFID_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_load = 1'b1;
          end else if (w_in_xfer) begin
            w_skid_load = 1'b1;
            w_state_nxt = IFID_TWO;
          end else if (w_out_xfer) begin
            w_main_clear = 1'b1;
            w_state_nxt  = IFID_EMPTY;
          end
        end
        IFID_TWO: begin
          if (w_out_xfer) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clear     = 1'b1;
            w_state_nxt      = IFID_ONE;
          end
        end
        default: w_state_nxt = IFID_EMPTY;
      endcase
    end
  end

  assign w_main_pc_d    = w_main_from_skid ? w_skid_pc    : in_pc;
  assign w_main_instr_d = w_main_from_skid ? w_skid_instr : in_instruction;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= (w_state_nxt != IFID_TWO);
    end
  end

  assign in_ready = r_in_ready;
`else
  // Single entry: ready whenever the entry is free or draining this cycle.
  assign in_ready       = !w_main_valid || out_ready;
  assign w_main_pc_d    = in_pc;
  assign w_main_instr_d = in_instruction;
  assign w_main_load    = w_in_xfer && !flush;
  assign w_main_clear   = flush || (w_out_xfer && !w_in_xfer);
`endif

endmodule
